line_mem_responder: RTL
=======================

// Module: line_mem_responder
// PURPOSE
//   Memory-side responder for the data cache's line refill/writeback traffic.
//   Accepts one 128-bit line request (read or write) over a valid/ready handshake.
//   Serves it from an internal word-wide RAM at one 32-bit beat per cycle, after a programmable access latency.
//   Returns a single-cycle response pulse.
//   Sits between the cache and backing storage, replacing the combinational line read of data memory.
// PARAMETERS
//   LATENCY      2    idle cycles between request accept and first RAM beat (0 allowed)
//   LINE_WORDS   4    32-bit words per cache line (fixed 4 for a 128-bit line)
//   DEPTH_WORDS  64   RAM depth in 32-bit words; must be a multiple of LINE_WORDS
// PORTS
//   clk         in   1    system clock, all logic on rising edge
//   reset       in   1    synchronous, active-low reset
//   req_valid   in   1    cache presents a line request
//   req_ready   out  1    responder can accept; high only in IDLE
//   req_write   in   1    1 = line write (writeback), 0 = line read (refill)
//   req_addr    in   32   byte address; bits [3:0] ignored (line aligned)
//   req_wdata   in   128  write line; word k = req_wdata[32k+31:32k]
//   resp_valid  out  1    one-cycle pulse: request complete
//   resp_rdata  out  128  read line, valid when resp_valid and read; held until next response
//   resp_err    out  1    qualifies resp_valid: address out of range
//   busy        out  1    high in every state except IDLE
// BEHAVIOUR
//   - Reset (reset==0 at a rising edge):
//     - state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; busy=0.
//     - RAM contents are NOT cleared.
//   - Accept edge: req_valid & req_ready.
//     - Latch req_write, line = req_addr[31:4] and req_wdata.
//     - Later changes on the req_* inputs are ignored until the next accept.
//   - Range check at accept: out of range when line >= DEPTH_WORDS/LINE_WORDS.
//     - No RAM access occurs.
//     - Go straight to RESP with resp_err=1 and resp_rdata=0.
//   - FSM IDLE -> WAIT -> XFER -> RESP -> IDLE.
//     - WAIT: count LATENCY cycles, then enter XFER; if LATENCY==0, skip WAIT.
//     - XFER: beat counter k = 0..LINE_WORDS-1, one word per cycle at RAM index line*LINE_WORDS+k.
//       - Write: RAM[idx] <= wdata word k.
//       - Read: rdata word k <= RAM[idx].
//       - After the last beat, enter RESP.
//     - RESP: resp_valid=1 for exactly one cycle, with resp_err as computed; next state IDLE.
//   - Latency: for an in-range request, resp_valid is high in cycle LATENCY+LINE_WORDS+1 after the accept edge.
//     - Default: cycle 7.
//     - Out-of-range: cycle 1.
//   - req_ready returns to 1 in the cycle after resp_valid.
//     - Back-to-back requests are therefore spaced by at least LATENCY+LINE_WORDS+2 cycles.
//   - req_valid while busy: ignored, never queued; the requester holds req_valid until req_ready.
//   - resp_rdata after a write response: unchanged from the previous read.
//   - Reset mid-operation: return to IDLE at once and drop the pending response.
//     - RAM words already written by completed beats stay written; partial lines are allowed.
//   - Beat counter and WAIT counter sized clog2 of their limits; neither wraps past its limit.
// TESTING
//   1. Reset, then write line 0x10 = {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}.
//      -> resp_valid at accept+7, resp_err=0, RAM[4..7] = AA,BB,CC,DD.
//   2. Read addr 0x1C (same line).
//      -> resp_valid at accept+7, resp_rdata = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
//   3. Read addr 0x100, line 16 >= 16.
//      -> resp_valid at accept+1, resp_err=1, rdata=0, RAM unchanged.
//   4. Pulse req_valid with a different address while busy.
//      -> no accept, req_ready=0, response matches the first request only.
//   5. Assert reset after beat 1 of a write to line 2.
//      -> no resp_valid; a later read returns new words 0-1 and old words 2-3.
//   6. LATENCY=0 build, read line 1.
//      -> resp_valid at accept+5; back-to-back reads are accepted every 6 cycles.

Source files
------------

// File: rtl/line_mem_if.sv
// Line request/response bus between the data cache and its memory responder.
// One outstanding line transfer at a time; the response is a single-cycle pulse.
interface line_mem_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for data-cache line refills and writebacks.
// Moves one 128-bit line through a word-wide RAM, one beat per cycle after a fixed latency.
module line_mem_responder #(
    parameter int LATENCY     = 2,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 64
) (
    input  logic      clk,
    input  logic      reset,
    line_mem_if.slave bus,
    output logic      busy
);
    localparam int NLINES = DEPTH_WORDS / LINE_WORDS;
    localparam int LW     = $clog2(NLINES);
    localparam int BW     = $clog2(LINE_WORDS);
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int AW     = LW + BW;

    localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

    state_t        state;
    state_t        state_n;
    logic          wr_q;
    logic [LW-1:0] line_q;
    logic [127:0]  wdata_q;
    logic [127:0]  rbuf;
    logic [127:0]  rline;
    logic [CW-1:0] wcnt;
    logic [BW-1:0] beat;
    logic [AW-1:0] idx;
    logic          accept;
    logic          in_range;
    logic          last_beat;
    logic          unused_addr;
    logic [31:0]   ram [DEPTH_WORDS];

    assign accept      = bus.req_valid && (state == IDLE);
    assign in_range    = bus.req_addr[31:4] < 28'(NLINES);
    assign last_beat   = (beat == BEAT_LAST);
    assign idx         = {line_q, beat};
    assign unused_addr = ^bus.req_addr[3:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n        = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        busy           = 1'b1;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
                if (accept) begin
                    if (!in_range) state_n = RESP;
                    else if (LATENCY == 0) state_n = XFER;
                    else state_n = WAIT;
                end
            end
            WAIT: if (wcnt == WAIT_LAST) state_n = XFER;
            XFER: if (last_beat) state_n = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Current beat merged into the partially assembled read line.
    always_comb begin
        rline                = rbuf;
        rline[beat*32 +: 32] = ram[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q           <= 1'b0;
            line_q         <= '0;
            wdata_q        <= '0;
            rbuf           <= '0;
            wcnt           <= '0;
            beat           <= '0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            if (accept) begin
                wr_q         <= bus.req_write;
                line_q       <= bus.req_addr[LW+3:4];
                wdata_q      <= bus.req_wdata;
                wcnt         <= '0;
                beat         <= '0;
                bus.resp_err <= !in_range;
                if (!in_range) bus.resp_rdata <= '0;
            end
            if (state == WAIT && wcnt != WAIT_LAST) begin
                wcnt <= wcnt + 1'b1;
            end
            if (state == XFER) begin
                if (!wr_q) rbuf <= rline;
                if (!last_beat) beat <= beat + 1'b1;
                else if (!wr_q) bus.resp_rdata <= rline;
            end
        end
    end

    // RAM is never cleared; reset only blocks the beat in flight.
    always_ff @(posedge clk) begin
        if (reset && state == XFER && wr_q) begin
            ram[idx] <= wdata_q[beat*32 +: 32];
        end
    end
endmodule
